// File: rtl/capture_pkg.sv
// Shared encodings for the sample-capture Wishbone slave: FSM states,
// register indices and CTRL/STATUS bit positions.
package capture_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

  localparam logic [1:0] RegCtrl  = 2'd0;
  localparam logic [1:0] RegDecim = 2'd1;
  localparam logic [1:0] RegCount = 2'd2;
  localparam logic [1:0] RegData  = 2'd3;

  localparam int unsigned CtrlArmBit     = 0;
  localparam int unsigned CtrlAbortBit   = 1;
  localparam int unsigned StatusEmptyBit = 2;
  localparam int unsigned StatusFullBit  = 3;

  localparam int unsigned DecimWidth = 16;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port with
// one-cycle registered read latency. Contents are not reset.
module capture_ram #(
  parameter int unsigned Width     = 17,
  parameter int unsigned DepthLog2 = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [DepthLog2-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [DepthLog2-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  localparam int unsigned Depth = 1 << DepthLog2;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/wb_capture_slave.sv
// Wishbone slave that records the generator's sample stream into a buffer for readback.
// Optional rising-zero-crossing trigger on arm: define CAPTURE_TRIGGER_EN.
module wb_capture_slave
  import capture_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 17,
  parameter int unsigned DEPTH_LOG2   = 10
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [1:0]              i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic [31:0]             o_wb_data,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_sample_valid,
  output logic                    o_done
);

  localparam int unsigned PtrW = DEPTH_LOG2 + 1;
  localparam logic [PtrW-1:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};

  cap_state_e            state_q;
  logic [DecimWidth-1:0] decim_q, dcnt_q;
  logic [PtrW-1:0]       count_q, rd_ptr_q;
  logic                  ack_q, stall_q, data_rd_q, data_ok_q;
  logic [31:0]           rdata_q;

  logic accept, wr_req, rd_req, arm, abort, empty, full;
  logic data_rd, pop, take, store;
  logic [31:0] reg_rdata;
  logic [SAMPLE_WIDTH-1:0] ram_rdata;

  logic unused_wdata;
  assign unused_wdata = ^i_wb_data[31:DecimWidth];

`ifdef CAPTURE_TRIGGER_EN
  // Only the sign of the previous valid sample matters for crossing detection.
  logic prev_neg_q, crossing;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_neg_q <= 1'b0;
    end else if (i_sample_valid) begin
      prev_neg_q <= i_sample[SAMPLE_WIDTH-1];
    end
  end
  assign crossing = prev_neg_q & ~i_sample[SAMPLE_WIDTH-1];
`endif

  always_comb begin
    accept  = i_wb_cyc & i_wb_stb & ~stall_q;
    wr_req  = accept & i_wb_we;
    rd_req  = accept & ~i_wb_we;
    arm     = wr_req & (i_wb_addr == RegCtrl) & i_wb_data[CtrlArmBit];
    abort   = wr_req & (i_wb_addr == RegCtrl) & i_wb_data[CtrlAbortBit];
    empty   = (rd_ptr_q == count_q);
    full    = (count_q == FullCount);
    data_rd = rd_req & (i_wb_addr == RegData);
    pop     = data_rd & ~empty;
    take    = 1'b0;
    if (i_sample_valid) begin
      if (state_q == StCapture) take = (dcnt_q == '0);
`ifdef CAPTURE_TRIGGER_EN
      else if (state_q == StArmed) take = crossing;
`endif
    end
    // arm restarts and abort stops, so neither may also store a sample
    store = take & ~arm & ~abort;
  end

  always_comb begin
    reg_rdata = '0;
    unique case (i_wb_addr)
      RegCtrl: begin
        reg_rdata[1:0]            = state_q;
        reg_rdata[StatusEmptyBit] = empty;
        reg_rdata[StatusFullBit]  = full;
      end
      RegDecim: reg_rdata[DecimWidth-1:0] = decim_q;
      RegCount: reg_rdata[PtrW-1:0]       = count_q;
      RegData:  reg_rdata                 = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      decim_q   <= '0;
      dcnt_q    <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      ack_q     <= 1'b0;
      stall_q   <= 1'b0;
      data_rd_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q     <= accept;
      stall_q   <= data_rd;
      data_rd_q <= data_rd;
      data_ok_q <= pop;
      rdata_q   <= rd_req ? reg_rdata : '0;
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_req && i_wb_addr == RegDecim) decim_q <= i_wb_data[DecimWidth-1:0];
      if (arm) begin
        state_q  <= StArmed;
        count_q  <= '0;
        rd_ptr_q <= '0;
        dcnt_q   <= '0;
      end else if (abort && (state_q == StArmed || state_q == StCapture)) begin
        state_q <= StIdle;
      end else if (store) begin
        count_q <= count_q + PtrW'(1);
        dcnt_q  <= decim_q;
        state_q <= (count_q + PtrW'(1) == FullCount) ? StDone : StCapture;
      end else begin
        if (state_q == StCapture && i_sample_valid) dcnt_q <= dcnt_q - DecimWidth'(1);
`ifndef CAPTURE_TRIGGER_EN
        if (state_q == StArmed) state_q <= StCapture;
`endif
      end
    end
  end

  capture_ram #(
    .Width    (SAMPLE_WIDTH),
    .DepthLog2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (i_clk),
    .we_i   (store),
    .waddr_i(count_q[DEPTH_LOG2-1:0]),
    .wdata_i(i_sample),
    .re_i   (pop),
    .raddr_i(rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o(ram_rdata)
  );

  // A master dropping cyc in the ack cycle abandons the transfer.
  assign o_wb_ack   = ack_q & i_wb_cyc;
  assign o_wb_stall = stall_q;
  assign o_done     = (state_q == StDone);

  always_comb begin
    o_wb_data = '0;
    if (o_wb_ack) begin
      if (!data_rd_q) begin
        o_wb_data = rdata_q;
      end else if (data_ok_q) begin
        o_wb_data = {{(32 - SAMPLE_WIDTH){ram_rdata[SAMPLE_WIDTH-1]}}, ram_rdata};
      end
    end
  end

endmodule

// File: tb/tb_wb_capture_slave.sv
// Directed self-checking bench for wb_capture_slave (default build and CAPTURE_TRIGGER_EN).
module tb_wb_capture_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdat = '0;
  logic        ack, stall, done;
  logic [31:0] rdat;
  logic [16:0] sample = '0;
  logic        svalid = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_capture_slave #(
    .SAMPLE_WIDTH(17),
    .DEPTH_LOG2  (10)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_wb_cyc      (cyc),
    .i_wb_stb      (stb),
    .i_wb_we       (we),
    .i_wb_addr     (addr),
    .i_wb_data     (wdat),
    .o_wb_ack      (ack),
    .o_wb_stall    (stall),
    .o_wb_data     (rdat),
    .i_sample      (sample),
    .i_sample_valid(svalid),
    .o_done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transfer; reports ack/data seen in the ack cycle and stall there.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, input logic drop,
                     output logic [31:0] rd, output logic stall_after, output logic acked);
    int n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
    while (stall && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 8) check("stall_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    stb = 1'b0;
    if (drop) cyc = 1'b0;
    #1;
    acked = ack; rd = rdat; stall_after = stall;
    @(posedge clk); #1;
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r; logic s, k;
    bus(1'b1, a, d, 1'b0, r, s, k);
    check("write_ack", 32'(k), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r; logic s, k;
    bus(1'b0, a, 32'd0, 1'b0, r, s, k);
    check({tag, "_ack"}, 32'(k), 32'd1);
    check(tag, r, exp);
    if (a == 2'd3) check({tag, "_stall"}, 32'(s), 32'd1);
  endtask

  task automatic push(input logic [16:0] s);
    sample = s; svalid = 1'b1;
    @(posedge clk); #1;
    svalid = 1'b0;
  endtask

  initial begin
    logic [31:0] r; logic s, k;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_data", rdat, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rd_chk("status_reset", 2'd0, 32'h4);
    rd_chk("count_reset", 2'd2, 32'd0);
    rd_chk("data_empty", 2'd3, 32'd0);
    rd_chk("decim_reset", 2'd1, 32'd0);

`ifndef CAPTURE_TRIGGER_EN
    // Full-buffer ramp with no decimation.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 1024; i++) begin
      sample = 17'(i); svalid = 1'b1;
      @(posedge clk); #1;
      if (i == 1022) check("not_done_1023", 32'(done), 32'd0);
    end
    svalid = 1'b0;
    check("done_flag", 32'(done), 32'd1);
    rd_chk("count_full", 2'd2, 32'd1024);
    rd_chk("status_full", 2'd0, 32'hB);
    for (int i = 0; i < 1024; i++) rd_chk("ramp_data", 2'd3, 32'(i));
    rd_chk("status_drained", 2'd0, 32'hF);
    rd_chk("data_drained", 2'd3, 32'd0);

    // Decimate by 4 then abort.
    wr(2'd1, 32'd3);
    rd_chk("decim_rb", 2'd1, 32'd3);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 40; i++) begin
      sample = 17'(i); svalid = 1'b1;
      @(posedge clk); #1;
    end
    svalid = 1'b0;
    wr(2'd0, 32'd2);
    rd_chk("status_abort", 2'd0, 32'h0);
    rd_chk("count_decim", 2'd2, 32'd10);
    wr(2'd2, 32'h55);
    rd_chk("count_ro", 2'd2, 32'd10);
    for (int i = 0; i < 10; i++) rd_chk("decim_data", 2'd3, 32'(4 * i));
    rd_chk("decim_empty", 2'd3, 32'd0);
    rd_chk("status_decim_empty", 2'd0, 32'h4);

    // Arm+abort together arms; sign extension; dropped cyc loses the pop.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd3);
    rd_chk("status_arm_abort", 2'd0, 32'h6);
    push(17'h1FFFF);
    push(17'h0FFFF);
    push(17'h00123);
    wr(2'd0, 32'd2);
    rd_chk("count_sign", 2'd2, 32'd3);
    rd_chk("sext_neg", 2'd3, 32'hFFFF_FFFF);
    rd_chk("sext_pos", 2'd3, 32'h0000_FFFF);
    bus(1'b0, 2'd3, 32'd0, 1'b1, r, s, k);
    check("drop_ack", 32'(k), 32'd0);
    check("drop_data", r, 32'd0);
    rd_chk("after_drop", 2'd3, 32'd0);
    rd_chk("status_after_drop", 2'd0, 32'h4);
`else
    // Rising zero crossing starts capture and is the first stored sample.
    wr(2'd0, 32'd1);
    rd_chk("trig_wait0", 2'd0, 32'h5);
    push(17'h1FFFB);
    rd_chk("trig_wait1", 2'd0, 32'h5);
    push(17'h1FFFD);
    rd_chk("trig_wait2", 2'd0, 32'h5);
    push(17'd2);
    rd_chk("trig_fired", 2'd0, 32'h2);
    push(17'd7);
    rd_chk("trig_count", 2'd2, 32'd2);
    rd_chk("trig_data0", 2'd3, 32'd2);
    rd_chk("trig_data1", 2'd3, 32'd7);
    rd_chk("trig_empty", 2'd3, 32'd0);
`endif

    // Reset in the ack cycle of a COUNT read at COUNT=500.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd1);
`ifdef CAPTURE_TRIGGER_EN
    push(17'h1FFFF);
`endif
    for (int i = 0; i < 500; i++) begin
      sample = 17'(i); svalid = 1'b1;
      @(posedge clk); #1;
    end
    svalid = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd2;
    @(posedge clk); #1;
    stb = 1'b0;
    check("pre_reset_ack", 32'(ack), 32'd1);
    check("pre_reset_count", rdat, 32'd500);
    rst = 1'b1;
    #1;
    check("mid_reset_ack", 32'(ack), 32'd0);
    check("mid_reset_data", rdat, 32'd0);
    check("mid_reset_stall", 32'(stall), 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("status_post_reset", 2'd0, 32'h4);
    rd_chk("count_post_reset", 2'd2, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_capture_slave.md
# wb_capture_slave

Wishbone responder that records the modulator's sample stream into an on-chip buffer so the UART/Wishbone host bridge can read it back for inspection. It sits on the same bus as the FM generator slave, answers a 4-word register page, and taps the generator's signed sample output. Capture is armed, optionally decimated, and stops automatically when the buffer fills.

## Interface
- SAMPLE_WIDTH, 17, signed sample width (sine_lookup_width+1)
- DEPTH_LOG2, 10, buffer holds 2^DEPTH_LOG2 samples
- i_clk  in  1  sole clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe, already qualified by the page decode
- i_wb_we  in  1  write enable
- i_wb_addr  in  2  register index
- i_wb_data  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  stall
- o_wb_data  out  32  read data
- i_sample  in  SAMPLE_WIDTH  signed sample from the generator
- i_sample_valid  in  1  sample qualifier
- o_done  out  1  high while state is DONE

## Operation
- Registers:
  - 0 CTRL/STATUS: write bit0=arm, bit1=abort. Read: [1:0] state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE), [2] empty, [3] full.
  - 1 DECIM: R/W, 16 bits. Capture every (DECIM+1)th valid sample.
  - 2 COUNT: read-only, DEPTH_LOG2+1 bits, number of samples written.
  - 3 DATA: read pops the sample at the read pointer, sign-extended to 32 bits.
  - Writes to 2 and 3 are acked and ignored.
- States:
  - IDLE: arm clears the write/read pointers and the decimation counter, then moves to ARMED.
  - ARMED moves to CAPTURE: next cycle, or on the trigger when configured.
  - CAPTURE: on each valid sample with decim counter==0, write the sample, increment COUNT and reload the counter with DECIM; otherwise decrement the counter.
  - COUNT reaching 2^DEPTH_LOG2 moves to DONE.
  - Abort from ARMED or CAPTURE moves to IDLE and keeps COUNT.
  - Arm from any state restarts the capture.
  - Abort and arm written together: arm wins.
- DATA read with rd_ptr==COUNT (empty): returns 0, pointer unchanged, still acked.
- Reads during CAPTURE are allowed and return only samples already written.

## Timing
- Request accepted when cyc & stb & !stall. Ack exactly one cycle later, with o_wb_data valid in the same cycle.
- o_wb_stall is high for the one cycle after an accepted DATA read, to allow for the RAM read latency. Otherwise it is 0.
- The DATA pop and all register writes take effect at acceptance.
- If cyc is low in the ack cycle, ack is suppressed. A popped sample is lost.
- o_wb_data is 0 in every cycle without ack.
- A sample accepted in cycle n is visible in COUNT in cycle n+1.
- A full condition in the same cycle as an arm write: arm wins.
- Reset values: o_wb_ack=0, o_wb_stall=0, o_wb_data=0, o_done=0, state IDLE, DECIM=0, pointers=0, COUNT=0.
- Reset mid-capture returns to IDLE immediately. Buffer contents are undefined, COUNT=0.

## Configuration
- CAPTURE_TRIGGER_EN
  - Defined: ARMED waits for a rising zero crossing, i.e. the previous valid sample is negative and the current one is ≥0. The crossing sample is the first one stored. STATUS reads 1 while waiting.
  - Undefined: ARMED lasts one cycle and capture starts with the next valid sample. The previous-sample register is not built.

## Structure
- capture_pkg: state encoding, register index constants, STATUS bit positions.
- Sub-module capture_ram: simple dual-port RAM, 2^DEPTH_LOG2 × SAMPLE_WIDTH, synchronous read with one-cycle latency, one write port and one read port.

## Test plan
- Reset, then read STATUS → 0x00000004. Read COUNT → 0. Read DATA → 0. Each ack arrives one cycle after acceptance.
- DECIM=0, arm, ramp 0..1023 with valid every cycle → DONE after 1024 samples, o_done=1, COUNT=1024, STATUS=0x0000000B. 1024 DATA reads return 0..1023, with stall high one cycle after each read.
- DECIM=3, arm, ramp 0..39, then abort → STATUS=0, COUNT=10. Reads return 0,4,...,36, then 0 with empty=1.
- Capture sample 17'h1FFFF → DATA reads 0xFFFFFFFF. Capture 17'h0FFFF → 0x0000FFFF.
- With CAPTURE_TRIGGER_EN, arm, samples −5,−3,2,7 → STATUS stays 1 until 2. COUNT=2, reads 2 then 7.
- Assert i_reset during CAPTURE at COUNT=500 → all outputs 0 within the same cycle. STATUS afterwards is 0x00000004.
